// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_stage_pkg;

   localparam int DATA_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Byte-write mask for one 64-bit RAM word: a single lane for byte
   // accesses, all eight lanes for doubleword accesses.
   function automatic logic [7:0] lane_mask(input logic byte_en, input logic [2:0] lane);
      logic [7:0] m;
      if (byte_en) begin
         m = 8'b0000_0001 << lane;
      end else begin
         m = 8'hFF;
      end
      return m;
   endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port data RAM with synchronous read and per-byte write enables.
// Latency: read data appears on o_rdat the cycle after i_en with i_we low.
// Backpressure: none; accepts one read or write per enabled cycle.
//
// Ports:
//   i_clk   clock
//   i_en    access enable (read when i_we=0, write when i_we=1)
//   i_we    write select
//   i_be    byte write enables, one per 8-bit lane
//   i_addr  word index
//   i_wdat  write data (lanes not enabled are ignored)
//   o_rdat  registered read data; holds its value between reads
module data_ram
   import mem_stage_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int WIDTH      = DATA_W
) (
   input  logic                  i_clk,
   input  logic                  i_en,
   input  logic                  i_we,
   input  logic [WIDTH/8-1:0]    i_be,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [WIDTH-1:0]      i_wdat,
   output logic [WIDTH-1:0]      o_rdat
);

   logic [WIDTH-1:0] r_mem [2**ADDR_WIDTH];

   // Contents are deliberately not reset.
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         if (i_we) begin
            for (int b = 0; b < WIDTH/8; b++) begin
               if (i_be[b]) begin
                  r_mem[i_addr][b*8 +: 8] <= i_wdat[b*8 +: 8];
               end
            end
         end else begin
            o_rdat <= r_mem[i_addr];
         end
      end
   end

endmodule

// File: rtl/mem_stage.sv
// ARMv8 pipeline MEM stage: LDUR/STUR/LDURB/STURB against an internal RAM, plus PCSrc.
// Latency: request at t0, LATENCY busy cycles, load result and read_valid_out in the DONE cycle.
// Backpressure: stall_out holds upstream for LATENCY+1 cycles per accepted access; faults never stall.
//
// Ports:
//   clock, reset           single clock, synchronous active-high reset
//   alu_result_in          byte address
//   read_data_2_in         store data
//   zero_in, branch_in,
//   uncond_branch_in       branch resolution inputs -> pc_src_out (combinational)
//   mem_read_in/_write_in  load / store request
//   byte_en_in             1 = byte access, 0 = doubleword
//   stall_out              upstream must hold its inputs
//   read_data_out          last load result (held)
//   read_valid_out         one-cycle pulse when a load completes
//   fault_out              one-cycle pulse when a request is rejected
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] read_data_2_in,
   input  logic              zero_in,
   input  logic              branch_in,
   input  logic              uncond_branch_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic              byte_en_in,
   output logic              pc_src_out,
   output logic              stall_out,
   output logic [DATA_W-1:0] read_data_out,
   output logic              read_valid_out,
   output logic              fault_out
);

   localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int BADDR_W = ADDR_WIDTH + 3;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [ADDR_WIDTH-1:0] r_widx;
   logic [2:0]            r_lane;
   logic                  r_is_wr;
   logic                  r_is_byte;
   logic [DATA_W-1:0]     r_wdat;
   logic [DATA_W-1:0]     r_rd_hold;
   logic                  r_rd_vld;

   logic                  w_req;
   logic                  w_fault_cond;
   logic                  w_idle;
   logic                  w_busy;
   logic                  w_accept;
   logic                  w_ram_en;
   logic [7:0]            w_be;
   logic [DATA_W-1:0]     w_ram_q;
   logic [7:0]            w_load_byte;
   logic [DATA_W-1:0]     w_load_val;

   assign pc_src_out = uncond_branch_in | (branch_in & zero_in);

   assign w_req  = mem_read_in | mem_write_in;
   assign w_idle = (r_state == ST_IDLE);
   assign w_busy = (r_state == ST_BUSY);

   // Reject: read+write together, unaligned doubleword, or address beyond the RAM.
   assign w_fault_cond = (mem_read_in & mem_write_in)
                       | (~byte_en_in & (|alu_result_in[2:0]))
                       | (|alu_result_in[DATA_W-1:BADDR_W]);

   assign w_accept = ~reset & w_idle & w_req & ~w_fault_cond;

   // Outputs read as zero while reset is held, matching their reset values.
   assign stall_out = ~reset & (w_accept | w_busy);
   assign fault_out = ~reset & w_idle & w_req & w_fault_cond;

   // The RAM is touched only in the final BUSY cycle; reset there discards the access.
   assign w_ram_en = ~reset & w_busy & (r_cnt == '0);
   assign w_be     = lane_mask(r_is_byte, r_lane);

   data_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WIDTH      (DATA_W)
   ) u_data_ram (
      .i_clk  (clock),
      .i_en   (w_ram_en),
      .i_we   (r_is_wr),
      .i_be   (w_be),
      .i_addr (r_widx),
      .i_wdat (r_wdat),
      .o_rdat (w_ram_q)
   );

   // Little-endian: lane n is bits [8n+7:8n]; byte loads zero-extend.
   assign w_load_byte = w_ram_q[{r_lane, 3'b000} +: 8];
   assign w_load_val  = r_is_byte ? {{(DATA_W-8){1'b0}}, w_load_byte} : w_ram_q;

   // The RAM word lands at the DONE edge, so in DONE the fresh value is
   // forwarded straight from the RAM and captured into the hold register.
   assign read_data_out  = ((r_state == ST_DONE) && r_rd_vld) ? w_load_val : r_rd_hold;
   assign read_valid_out = r_rd_vld;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_rd_vld  <= 1'b0;
         r_rd_hold <= '0;
      end else begin
         r_rd_vld <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state <= ST_BUSY;
                  r_cnt   <= CNT_W'(LATENCY - 1);
               end
            end
            ST_BUSY: begin
               if (r_cnt == '0) begin
                  r_state  <= ST_DONE;
                  r_rd_vld <= ~r_is_wr;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_DONE: begin
               // Upstream still shows the finished request here; it is ignored.
               r_state <= ST_IDLE;
               if (r_rd_vld) begin
                  r_rd_hold <= w_load_val;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Request capture; byte stores replicate the byte so the lane mask alone selects it.
   always_ff @(posedge clock) begin
      if (w_accept) begin
         r_widx    <= alu_result_in[BADDR_W-1:3];
         r_lane    <= alu_result_in[2:0];
         r_is_wr   <= mem_write_in;
         r_is_byte <= byte_en_in;
         r_wdat    <= byte_en_in ? {8{read_data_2_in[7:0]}} : read_data_2_in;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// checked every cycle against a byte-array memory model and an access timeline.
module tb_mem_stage;

   localparam int AW     = 10;
   localparam int LAT    = 2;
   localparam int NBYTES = 8 * (1 << AW);

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] alu_result_in = '0;
   logic [63:0] read_data_2_in = '0;
   logic        zero_in = 1'b0;
   logic        branch_in = 1'b0;
   logic        uncond_branch_in = 1'b0;
   logic        mem_read_in = 1'b0;
   logic        mem_write_in = 1'b0;
   logic        byte_en_in = 1'b0;
   logic        pc_src_out;
   logic        stall_out;
   logic [63:0] read_data_out;
   logic        read_valid_out;
   logic        fault_out;

   always #5 clock = ~clock;

   mem_stage #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
      .clock            (clock),
      .reset            (reset),
      .alu_result_in    (alu_result_in),
      .read_data_2_in   (read_data_2_in),
      .zero_in          (zero_in),
      .branch_in        (branch_in),
      .uncond_branch_in (uncond_branch_in),
      .mem_read_in      (mem_read_in),
      .mem_write_in     (mem_write_in),
      .byte_en_in       (byte_en_in),
      .pc_src_out       (pc_src_out),
      .stall_out        (stall_out),
      .read_data_out    (read_data_out),
      .read_valid_out   (read_valid_out),
      .fault_out        (fault_out)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   bit   chk_on = 1'b0;
   bit   fin    = 1'b0;

   logic [7:0] mb [NBYTES];
   bit         kb [NBYTES];

   // results of the most recent access() call
   int          ns, va, nc;
   logic [63:0] vd;
   logic        f0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", nm, cyc, act, exp);
      end
   endtask

   // Reference model: each accepted request owns cycles acc..acc+LAT+1
   // (request, LAT busy cycles, done). Memory is modelled per byte.
   task automatic compare_loop();
      int          acc = -1000;
      bit          a_wr = 0, a_be = 0, a_kn = 0;
      logic [63:0] a_addr = '0, a_dat = '0, a_val = '0;
      logic [63:0] e_rd = '0;
      bit          e_kn = 1;
      bit          busy, done, req, bad, acpt;
      logic        e_stall, e_fault, e_vld;
      while (!fin) begin
         @(negedge clock);
         cyc++;
         if (chk_on) begin
            busy  = (cyc > acc) && (cyc <= acc + LAT);
            done  = (cyc == acc + LAT + 1);
            e_vld = done && !a_wr;
            if (done) begin
               if (!a_wr) begin
                  e_rd = a_val;
                  e_kn = a_kn;
               end else if (a_be) begin
                  mb[int'(a_addr)] = a_dat[7:0];
                  kb[int'(a_addr)] = 1'b1;
               end else begin
                  for (int i = 0; i < 8; i++) begin
                     mb[int'(a_addr) + i] = a_dat[i*8 +: 8];
                     kb[int'(a_addr) + i] = 1'b1;
                  end
               end
            end
            req  = mem_read_in || mem_write_in;
            bad  = (mem_read_in && mem_write_in) ||
                   (!byte_en_in && (alu_result_in % 8 != 0)) ||
                   (alu_result_in >= 64'(NBYTES));
            acpt = !busy && !done && req && !bad;
            e_stall = !reset && (busy || acpt);
            e_fault = !reset && !busy && !done && req && bad;

            chk("pc_src", 64'(pc_src_out), 64'(uncond_branch_in || (branch_in && zero_in)));
            chk("stall", 64'(stall_out), 64'(e_stall));
            chk("fault", 64'(fault_out), 64'(e_fault));
            chk("read_valid", 64'(read_valid_out), 64'(e_vld));
            if (e_kn) chk("read_data", read_data_out, e_rd);

            if (acpt && !reset) begin
               acc    = cyc;
               a_wr   = mem_write_in;
               a_be   = byte_en_in;
               a_addr = alu_result_in;
               a_dat  = read_data_2_in;
               a_kn   = 1'b1;
               a_val  = '0;
               if (!a_wr) begin
                  if (a_be) begin
                     a_val[7:0] = mb[int'(a_addr)];
                     a_kn       = kb[int'(a_addr)];
                  end else begin
                     for (int i = 0; i < 8; i++) begin
                        a_val[i*8 +: 8] = mb[int'(a_addr) + i];
                        a_kn = a_kn && kb[int'(a_addr) + i];
                     end
                  end
               end
            end
            if (reset) begin
               acc  = -1000;
               e_rd = '0;
               e_kn = 1'b1;
            end
         end
      end
   endtask

   // Presents one request, honouring stall_out; optional reset at cycle rst_at.
   task automatic access(input logic rd, input logic wr, input logic be,
                         input logic [63:0] a, input logic [63:0] d, input int rst_at,
                         output int n_st, output int v_at, output logic [63:0] v_dat,
                         output logic flt0, output int n_cyc);
      logic s;
      bit   ok;
      alu_result_in  = a;
      read_data_2_in = d;
      mem_read_in    = rd;
      mem_write_in   = wr;
      byte_en_in     = be;
      n_st = 0; v_at = -1; v_dat = '0; flt0 = 1'b0; n_cyc = 0; ok = 1'b0;
      for (int k = 0; k < 12 && !ok; k++) begin
         if (k == rst_at) reset = 1'b1;
         @(negedge clock);
         n_cyc++;
         if (stall_out) n_st++;
         if (k == 0) flt0 = fault_out;
         if (read_valid_out === 1'b1 && v_at < 0) begin
            v_at  = k;
            v_dat = read_data_out;
         end
         s = stall_out;
         @(posedge clock);
         #1;
         if (reset) begin
            reset = 1'b0;
            ok    = 1'b1;
         end else if (!s) begin
            ok = 1'b1;
         end
      end
      mem_read_in  = 1'b0;
      mem_write_in = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL access_timeout (cycle %0d): addr %h still stalled after 12 cycles", cyc, a);
      end
   endtask

   task automatic main_seq();
      int          va1, nc1;
      logic [63:0] vd1, pre;

      repeat (3) @(posedge clock);
      #1;
      reset  = 1'b0;
      chk_on = 1'b1;
      @(negedge clock);
      chk("rst_stall", 64'(stall_out), 64'd0);
      chk("rst_rdata", read_data_out, 64'd0);
      chk("rst_valid", 64'(read_valid_out), 64'd0);
      chk("rst_fault", 64'(fault_out), 64'd0);
      @(posedge clock);
      #1;

      // doubleword store then load
      access(0, 1, 0, 64'h10, 64'h1122334455667788, -1, ns, va, vd, f0, nc);
      chk("stur_stall_cycles", 64'(ns), 64'd3);
      chk("stur_no_fault", 64'(f0), 64'd0);
      access(1, 0, 0, 64'h10, 64'h0, -1, ns, va, vd, f0, nc);
      chk("ldur_valid_cycle", 64'(va), 64'd3);
      chk("ldur_data", vd, 64'h1122334455667788);

      // byte store / byte load
      access(0, 1, 1, 64'h13, 64'h55555555555555AB, -1, ns, va, vd, f0, nc);
      chk("sturb_stall_cycles", 64'(ns), 64'd3);
      access(1, 0, 0, 64'h10, 64'h0, -1, ns, va, vd, f0, nc);
      chk("ldur_after_sturb", vd, 64'h11223344AB667788);
      access(1, 0, 1, 64'h13, 64'h0, -1, ns, va, vd, f0, nc);
      chk("ldurb_valid_cycle", 64'(va), 64'd3);
      chk("ldurb_data", vd, 64'h00000000000000AB);

      // faults
      access(1, 0, 0, 64'h14, 64'h0, -1, ns, va, vd, f0, nc);
      chk("misalign_fault", 64'(f0), 64'd1);
      chk("misalign_no_stall", 64'(ns), 64'd0);
      chk("misalign_no_valid", 64'(va < 0), 64'd1);
      access(1, 0, 0, 64'h2000, 64'h0, -1, ns, va, vd, f0, nc);
      chk("range_fault", 64'(f0), 64'd1);
      chk("range_no_stall", 64'(ns), 64'd0);
      access(1, 1, 0, 64'h10, 64'h0, -1, ns, va, vd, f0, nc);
      chk("rdwr_fault", 64'(f0), 64'd1);
      chk("rdwr_no_stall", 64'(ns), 64'd0);
      chk("rdwr_no_valid", 64'(va < 0), 64'd1);
      chk("fault_rdata_held", read_data_out, 64'h00000000000000AB);

      // reset in the final busy cycle discards the store
      access(0, 1, 0, 64'h20, 64'h0, -1, ns, va, vd, f0, nc);
      access(0, 1, 0, 64'h20, 64'hDEAD, 2, ns, va, vd, f0, nc);
      @(negedge clock);
      chk("post_reset_stall", 64'(stall_out), 64'd0);
      @(posedge clock);
      #1;
      access(1, 0, 0, 64'h20, 64'h0, -1, ns, va, vd, f0, nc);
      chk("post_reset_valid_cycle", 64'(va), 64'd3);
      chk("post_reset_load", vd, 64'h0);

      // branch resolution, while stalled
      alu_result_in = 64'h10; byte_en_in = 1'b0; mem_read_in = 1'b1;
      branch_in = 1'b1; zero_in = 1'b1; uncond_branch_in = 1'b0;
      @(negedge clock);
      chk("br_taken_pc", 64'(pc_src_out), 64'd1);
      chk("br_taken_stall", 64'(stall_out), 64'd1);
      @(posedge clock); #1;
      zero_in = 1'b0;
      @(negedge clock);
      chk("br_not_taken_pc", 64'(pc_src_out), 64'd0);
      chk("br_not_taken_stall", 64'(stall_out), 64'd1);
      @(posedge clock); #1;
      uncond_branch_in = 1'b1;
      @(negedge clock);
      chk("uncond_pc", 64'(pc_src_out), 64'd1);
      chk("uncond_stall", 64'(stall_out), 64'd1);
      @(posedge clock); #1;
      @(negedge clock);
      chk("br_load_valid", 64'(read_valid_out), 64'd1);
      chk("br_load_data", read_data_out, 64'h11223344AB667788);
      @(posedge clock); #1;
      mem_read_in = 1'b0; branch_in = 1'b0; uncond_branch_in = 1'b0;

      // back-to-back loads
      access(0, 1, 0, 64'h28, 64'hCAFEF00D12345678, -1, ns, va, vd, f0, nc);
      access(1, 0, 0, 64'h10, 64'h0, -1, ns, va1, vd1, f0, nc1);
      access(1, 0, 0, 64'h28, 64'h0, -1, ns, va, vd, f0, nc);
      chk("b2b_first_data", vd1, 64'h11223344AB667788);
      chk("b2b_second_data", vd, 64'hCAFEF00D12345678);
      chk("b2b_spacing", 64'(nc1 - va1 + va), 64'd4);

      // randomized traffic over 16 words (low and top of the RAM)
      for (int w = 0; w < 16; w++) begin
         access(0, 1, 0, 64'((w < 8 ? w : 1016 + w - 8) * 8), {$urandom, $urandom}, -1, ns, va, vd, f0, nc);
      end
      for (int i = 0; i < 300; i++) begin
         int          r, w, wi, ln, ra;
         logic        rd, wr, be;
         logic [63:0] a;
         r  = $urandom_range(0, 99);
         w  = $urandom_range(0, 15);
         wi = (w < 8) ? w : 1016 + w - 8;
         ln = $urandom_range(0, 7);
         ra = -1;
         branch_in        = 1'($urandom_range(0, 1));
         zero_in          = 1'($urandom_range(0, 1));
         uncond_branch_in = 1'($urandom_range(0, 1));
         rd = 1'b1; wr = 1'b0; be = 1'b0; a = 64'(wi * 8);
         if (r < 30) begin
            rd = 1'b1;
         end else if (r < 48) begin
            rd = 1'b0; wr = 1'b1;
         end else if (r < 62) begin
            be = 1'b1; a = 64'(wi * 8 + ln);
         end else if (r < 76) begin
            rd = 1'b0; wr = 1'b1; be = 1'b1; a = 64'(wi * 8 + ln);
         end else if (r < 82) begin
            wr = 1'($urandom_range(0, 1)); rd = !wr;
            a  = 64'(wi * 8 + $urandom_range(1, 7));
         end else if (r < 88) begin
            wr = 1'($urandom_range(0, 1)); rd = !wr; be = 1'($urandom_range(0, 1));
            a  = {32'($urandom), 32'($urandom)} | 64'h2000;
         end else if (r < 92) begin
            rd = 1'b1; wr = 1'b1; be = 1'($urandom_range(0, 1)); a = 64'(wi * 8 + ln);
         end else if (r >= 96) begin
            wr = 1'($urandom_range(0, 1)); rd = !wr;
            ra = $urandom_range(0, 3);
         end
         if (r >= 92 && r < 96) begin
            @(posedge clock);
            #1;
         end else begin
            access(rd, wr, be, a, {$urandom, $urandom}, ra, ns, va, vd, f0, nc);
         end
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      fork
         compare_loop();
         begin
            main_seq();
            fin = 1'b1;
         end
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
